// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state codes, opcode set and instruction width.
package cpu_pkg;

  localparam int INST_W = 32;

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_FETCH      = 3'd1,
    S_DECODE     = 3'd2,
    S_EXECUTE    = 3'd3,
    S_MEMORY     = 3'd4,
    S_WRITEBACK  = 3'd5,
    S_HALTED     = 3'd6,
    S_FAULT      = 3'd7
  } seq_state_e;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  function automatic logic is_mem_op(input logic [INST_W-1:0] inst);
    return (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_STORE);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer bus: memory handshakes, control-unit strobes, halt and debug/status signals.
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic              CORE_RST;
  logic              IMEM_REQ;
  logic              IMEM_ACK;
  logic [INST_W-1:0] IMEM_DATA;
  logic [INST_W-1:0] INST;
  logic              INST_ENB;
  logic              CU_WRITE_ENB;
  logic              DMEM_REQ;
  logic              DMEM_ACK;
  logic              RF_WE;
  logic              PC_CLK;
  logic              HALT;
  logic              HALTED;
  logic [2:0]        STATE;
  logic [31:0]       INSTRET;
  logic              FAULT;

  modport master (
    output CORE_RST, IMEM_REQ, INST, INST_ENB, DMEM_REQ, RF_WE, PC_CLK,
           HALTED, STATE, INSTRET, FAULT,
    input  IMEM_ACK, IMEM_DATA, CU_WRITE_ENB, DMEM_ACK, HALT
  );

  modport slave (
    input  CORE_RST, IMEM_REQ, INST, INST_ENB, DMEM_REQ, RF_WE, PC_CLK,
           HALTED, STATE, INSTRET, FAULT,
    output IMEM_ACK, IMEM_DATA, CU_WRITE_ENB, DMEM_ACK, HALT
  );
endinterface

// File: rtl/seq_wait_timer.sv
// Handshake wait counter: clears while idle, counts un-acknowledged wait cycles,
// and flags expiry on the LIMIT-th such cycle.
module seq_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 8'd1;
  end

  assign expired = inc && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with reset hold, halt and retire count.
// Defining CPU_SEQ_TIMEOUT_EN adds a handshake timeout that parks the core in FAULT.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic            CLK,
  input  logic            RST,
  cpu_sequencer_if.master bus
);
  localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       instret_q, instret_d;
  logic core_rst_q, core_rst_d, imem_req_q, imem_req_d, inst_enb_q, inst_enb_d;
  logic dmem_req_q, dmem_req_d, rf_we_q, rf_we_d, pc_clk_q, pc_clk_d;
  logic halted_q, halted_d, fault_q, fault_d;
  logic wait_expired;

`ifdef CPU_SEQ_TIMEOUT_EN
  logic waiting, wait_ack;
  assign waiting  = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign wait_ack = (state_q == S_FETCH) ? bus.IMEM_ACK : bus.DMEM_ACK;

  seq_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .clk     (CLK),
    .rst     (RST),
    .clr     (!waiting),
    .inc     (waiting && !wait_ack),
    .expired (wait_expired)
  );
`else
  // Waits are unbounded; TIMEOUT_CYCLES only matters when the timer is built.
  assign wait_expired = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    inst_d     = inst_q;
    instret_d  = instret_q;
    case (state_q)
      S_RESET_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = bus.HALT ? S_HALTED : S_FETCH;
        else                         hold_cnt_d = hold_cnt_q + 8'd1;
      end
      S_FETCH: begin
        if (bus.IMEM_ACK) begin
          inst_d  = bus.IMEM_DATA;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = is_mem_op(inst_q) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (bus.DMEM_ACK)  state_d = S_WRITEBACK;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_WRITEBACK: begin
        instret_d = instret_q + 32'd1;
        state_d   = bus.HALT ? S_HALTED : S_FETCH;
      end
      S_HALTED: if (!bus.HALT) state_d = S_FETCH;
      default:  state_d = state_q;
    endcase

    // Outputs are decoded from the next state so they flop out glitch-free.
    core_rst_d = (state_d == S_RESET_HOLD);
    imem_req_d = (state_d == S_FETCH);
    inst_enb_d = (state_d == S_DECODE);
    dmem_req_d = (state_d == S_MEMORY);
    pc_clk_d   = (state_d == S_WRITEBACK);
    rf_we_d    = (state_d == S_WRITEBACK) && (bus.CU_WRITE_ENB || (inst_d[6:0] == OP_LOAD));
    halted_d   = (state_d == S_HALTED);
`ifdef CPU_SEQ_TIMEOUT_EN
    fault_d    = (state_d == S_FAULT);
`else
    fault_d    = 1'b0;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_RESET_HOLD;
      hold_cnt_q <= '0;
      inst_q     <= '0;
      instret_q  <= '0;
      core_rst_q <= 1'b1;
      imem_req_q <= 1'b0;
      inst_enb_q <= 1'b0;
      dmem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_clk_q   <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      inst_q     <= inst_d;
      instret_q  <= instret_d;
      core_rst_q <= core_rst_d;
      imem_req_q <= imem_req_d;
      inst_enb_q <= inst_enb_d;
      dmem_req_q <= dmem_req_d;
      rf_we_q    <= rf_we_d;
      pc_clk_q   <= pc_clk_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.CORE_RST = core_rst_q;
  assign bus.IMEM_REQ = imem_req_q;
  assign bus.INST     = inst_q;
  assign bus.INST_ENB = inst_enb_q;
  assign bus.DMEM_REQ = dmem_req_q;
  assign bus.RF_WE    = rf_we_q;
  assign bus.PC_CLK   = pc_clk_q;
  assign bus.HALTED   = halted_q;
  assign bus.STATE    = state_q;
  assign bus.INSTRET  = instret_q;
  assign bus.FAULT    = fault_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed vector table, hand-written halt/reset/timeout sequences,
// and random instruction streams checked against a transaction-level latency/strobe model.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_sequencer_if bus();

  cpu_sequencer #(.RESET_HOLD_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] instret_exp = '0;

  typedef struct {
    logic [31:0] inst;
    logic        cu;
    int          fw;
    int          mw;
    logic        rf;
    int          lat;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rules: fetch waits + decode + execute + optional memory access + writeback.
  function automatic int model_latency(input logic [31:0] inst, input int fw, input int mw);
    logic [6:0] op;
    op = inst[6:0];
    return (fw + 1) + 1 + 1 + (((op == 7'h03) || (op == 7'h23)) ? (mw + 1) : 0) + 1;
  endfunction

  function automatic logic model_rf_we(input logic [31:0] inst, input logic cu);
    logic [6:0] op;
    op = inst[6:0];
    return cu || (op == 7'h03);
  endfunction

  // Starts in a FETCH cycle; acts as memory with fw/mw wait cycles and random ignored ACKs.
  task automatic run_inst(input string name, input logic [31:0] inst, input logic cu,
                          input int fw, input int mw, input logic exp_rf, input int exp_lat);
    int lat = 0, fc = 0, mc = 0, enb = 0, enb_at = 0;
    bit done = 0, clash = 0;
    logic rf_seen = 1'b0;
    logic [31:0] inst_wb = '0;
    bus.CU_WRITE_ENB = cu;
    while (!done && lat < 64) begin
      lat++;
      if (bus.IMEM_REQ) begin
        bus.IMEM_ACK  = (fc == fw);
        bus.IMEM_DATA = (fc == fw) ? inst : $urandom;
        fc++;
      end else begin
        bus.IMEM_ACK  = 1'($urandom);
        bus.IMEM_DATA = $urandom;
      end
      if (bus.DMEM_REQ) begin
        bus.DMEM_ACK = (mc == mw);
        mc++;
      end else begin
        bus.DMEM_ACK = 1'($urandom);
      end
      if (bus.INST_ENB) begin
        enb++;
        enb_at = lat;
        if (bus.INST !== inst) clash = 1;
        if (bus.PC_CLK || bus.RF_WE) clash = 1;
      end
      if (bus.PC_CLK) begin
        done    = 1;
        rf_seen = bus.RF_WE;
        inst_wb = bus.INST;
      end else if (bus.RF_WE) begin
        clash = 1;
      end
      step();
    end
    instret_exp++;
    chk({name, " retired"}, 32'(done), 32'd1);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " rf_we"}, 32'(rf_seen), 32'(exp_rf));
    chk({name, " inst_enb count"}, enb, 1);
    chk({name, " inst_enb cycle"}, enb_at, fw + 2);
    chk({name, " strobe overlap"}, 32'(clash), 32'd0);
    chk({name, " inst at wb"}, inst_wb, inst);
    chk({name, " instret"}, bus.INSTRET, instret_exp);
  endtask

  initial begin
    bit pc_seen;
    logic [31:0] rnd, inst;
    logic [6:0] op;
    int fw, mw;
    logic cu;

    tbl[0] = '{32'h002081B3, 1'b1, 0, 0, 1'b1, 4};
    tbl[1] = '{32'h0000A103, 1'b0, 0, 3, 1'b1, 8};
    tbl[2] = '{32'h0020A023, 1'b0, 1, 0, 1'b0, 6};
    tbl[3] = '{32'h0000007F, 1'b0, 0, 0, 1'b0, 4};
    tbl[4] = '{32'h1234567B, 1'b1, 2, 0, 1'b1, 6};
    tbl[5] = '{32'h00108093, 1'b0, 0, 0, 1'b0, 4};
    tbl[6] = '{32'h0000A103, 1'b1, 0, 0, 1'b1, 5};

    rst = 1'b1;
    bus.IMEM_ACK = 1'b0; bus.IMEM_DATA = '0; bus.DMEM_ACK = 1'b0;
    bus.CU_WRITE_ENB = 1'b0; bus.HALT = 1'b0;
    step(); step();
    chk("reset state", 32'(bus.STATE), 32'd0);
    chk("reset core_rst", 32'(bus.CORE_RST), 32'd1);
    chk("reset imem_req", 32'(bus.IMEM_REQ), 32'd0);
    chk("reset instret", bus.INSTRET, 32'd0);

    // Reset hold: CORE_RST for exactly four cycles after release.
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("hold cycle %0d core_rst", i), 32'(bus.CORE_RST), 32'd1);
    end
    step();
    chk("hold exit core_rst", 32'(bus.CORE_RST), 32'd0);
    chk("hold exit imem_req", 32'(bus.IMEM_REQ), 32'd1);
    chk("hold exit state", 32'(bus.STATE), 32'd1);

    for (int i = 0; i < 7; i++)
      run_inst($sformatf("vec%0d", i), tbl[i].inst, tbl[i].cu, tbl[i].fw, tbl[i].mw,
               tbl[i].rf, tbl[i].lat);

    // Halt raised during EXECUTE: the instruction still retires, then parks.
    bus.CU_WRITE_ENB = 1'b1;
    bus.IMEM_ACK = 1'b1; bus.IMEM_DATA = 32'h002081B3;
    step();
    chk("halt decode enb", 32'(bus.INST_ENB), 32'd1);
    step();
    chk("halt execute state", 32'(bus.STATE), 32'd3);
    bus.HALT = 1'b1;
    step();
    chk("halt wb pc_clk", 32'(bus.PC_CLK), 32'd1);
    step();
    instret_exp++;
    chk("halted flag", 32'(bus.HALTED), 32'd1);
    chk("halted no fetch", 32'(bus.IMEM_REQ), 32'd0);
    chk("halted instret", bus.INSTRET, instret_exp);
    step(); step();
    chk("halted state held", 32'(bus.STATE), 32'd6);
    bus.HALT = 1'b0;
    step();
    chk("unhalt state", 32'(bus.STATE), 32'd1);
    chk("unhalt imem_req", 32'(bus.IMEM_REQ), 32'd1);
    chk("unhalt halted", 32'(bus.HALTED), 32'd0);

    for (int n = 0; n < 40; n++) begin
      rnd = $urandom;
      case ($urandom_range(0, 4))
        0: op = 7'h03;
        1: op = 7'h23;
        2: op = 7'h33;
        3: op = 7'h13;
        default: op = 7'($urandom);
      endcase
      inst = {rnd[31:7], op};
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      cu = 1'($urandom);
      run_inst($sformatf("rand%0d", n), inst, cu, fw, mw, model_rf_we(inst, cu),
               model_latency(inst, fw, mw));
    end

    // Reset in the middle of a stalled load: abort without retiring.
    bus.CU_WRITE_ENB = 1'b1;
    bus.IMEM_ACK = 1'b1; bus.IMEM_DATA = 32'h0000A103; bus.DMEM_ACK = 1'b0;
    step(); step(); step();
    chk("mid memory dmem_req", 32'(bus.DMEM_REQ), 32'd1);
    step();
    #2 rst = 1'b1;
    #1;
    chk("async rst dmem_req", 32'(bus.DMEM_REQ), 32'd0);
    chk("async rst state", 32'(bus.STATE), 32'd0);
    chk("async rst core_rst", 32'(bus.CORE_RST), 32'd1);
    chk("async rst inst", bus.INST, 32'd0);
    chk("async rst instret", bus.INSTRET, 32'd0);
    chk("async rst fault", 32'(bus.FAULT), 32'd0);
    pc_seen = bus.PC_CLK | bus.RF_WE | bus.INST_ENB | bus.HALTED | bus.IMEM_REQ;
    for (int i = 0; i < 3; i++) begin
      step();
      pc_seen |= bus.PC_CLK | bus.RF_WE;
    end
    chk("abort strobes", 32'(pc_seen), 32'd0);

    // HALT held across release: reset hold exits straight to HALTED.
    bus.HALT = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("reset to halted", 32'(bus.STATE), 32'd6);
    bus.IMEM_ACK = 1'b0;
    bus.HALT = 1'b0;
    step();
    chk("halted to fetch", 32'(bus.STATE), 32'd1);

`ifdef CPU_SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    chk("timeout pending fault", 32'(bus.FAULT), 32'd0);
    chk("timeout pending state", 32'(bus.STATE), 32'd1);
    step();
    chk("timeout fault", 32'(bus.FAULT), 32'd1);
    chk("timeout state", 32'(bus.STATE), 32'd7);
    for (int i = 0; i < 6; i++) begin
      bus.IMEM_ACK = 1'($urandom); bus.DMEM_ACK = 1'($urandom); bus.HALT = 1'($urandom);
      step();
    end
    chk("fault sticky", 32'(bus.FAULT), 32'd1);
    chk("fault no requests", 32'({bus.IMEM_REQ, bus.DMEM_REQ, bus.PC_CLK}), 32'd0);
    bus.HALT = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst clears fault", 32'(bus.FAULT), 32'd0);
    step();
    rst = 1'b0;
`else
    for (int i = 0; i < 40; i++) step();
    chk("unbounded fetch state", 32'(bus.STATE), 32'd1);
    chk("unbounded fetch fault", 32'(bus.FAULT), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
